// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// address geometry and instruction constants.
package fetch_unit_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam int          PC_W        = 64;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of {PC, instruction} pairs between the
// instruction memory response port and the controller stage.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [PC_W-1:0]        push_pc,
  input  logic [BITS-1:0]        push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [PC_W-1:0]        head_pc,
  output logic [BITS-1:0]        head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] pc_mem_r   [DEPTH];
  logic [BITS-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  // Push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (flush) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_pop_s  = pop && (count_r != CW'(0));
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end
  end

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= '0;
        data_mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      pc_mem_r[wr_ptr_r]   <= push_pc;
      data_mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Head is forced to zero when empty so stale entries never leak out.
  always_comb begin
    head_pc   = '0;
    head_data = '0;
    if (count_r != CW'(0)) begin
      head_pc   = pc_mem_r[rd_ptr_r];
      head_data = data_mem_r[rd_ptr_r];
    end else begin
      head_pc   = '0;
      head_data = '0;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers in-order
// responses for the controller, and drains stale responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          BITS     = 32,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ImemReqValid,
  input  logic            ImemReqReady,
  output logic [63:0]     ImemReqAddr,
  input  logic            ImemRspValid,
  input  logic [BITS-1:0] ImemRspData,
  input  logic            Redirect,
  input  logic [63:0]     RedirectPC,
  output logic            InstrValid,
  input  logic            InstrReady,
  output logic [BITS-1:0] Instruction,
  output logic [63:0]     InstrPC,
  output logic            Misaligned
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t    state_r, state_s;
  logic [PC_W-1:0] fetch_pc_r, fetch_pc_s;
  logic [PC_W-1:0] rsp_pc_r, rsp_pc_s;
  logic [CW-1:0]   outstanding_r, outstanding_s;
  logic [CW-1:0]   drop_r, drop_s;
  logic            misaligned_r;
  logic [CW-1:0]   buf_count_s;
  logic [PC_W-1:0] target_pc_s;
  logic            room_s;
  logic            req_valid_s;
  logic            req_acc_s;
  logic            rsp_s;
  logic            push_s;
  logic            pop_s;

  assign target_pc_s = align_pc(RedirectPC);

  // Request/response handshakes; capacity counts both in-flight and buffered words.
  always_comb begin
    room_s      = (({1'b0, outstanding_r} + {1'b0, buf_count_s}) < DEPTH_W);
    rsp_s       = ImemRspValid && (outstanding_r != CW'(0));
    req_valid_s = 1'b0;
    if (!rst && (state_r == FETCH) && !Redirect && room_s) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    req_acc_s = req_valid_s && ImemReqReady;
    push_s    = rsp_s && (state_r == FETCH) && !Redirect;
    pop_s     = InstrValid && InstrReady && !Redirect;
  end

  // In-flight request count.
  always_comb begin
    outstanding_s = outstanding_r;
    case ({req_acc_s, rsp_s})
      2'b10:   outstanding_s = outstanding_r + CW'(1);
      2'b01:   outstanding_s = outstanding_r - CW'(1);
      default: outstanding_s = outstanding_r;
    endcase
  end

  // Next state. Responses return in order, so the PC of the next response is
  // simply the running successor of the last redirect target.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    rsp_pc_s   = rsp_pc_r;
    drop_s     = drop_r;
    if (Redirect) begin
      fetch_pc_s = target_pc_s;
      rsp_pc_s   = target_pc_s;
      drop_s     = outstanding_s;
      if (outstanding_s != CW'(0)) begin
        state_s = DRAIN;
      end else begin
        state_s = FETCH;
      end
    end else begin
      case (state_r)
        FETCH: begin
          if (req_acc_s) begin
            fetch_pc_s = fetch_pc_r + PC_W'(INSTR_BYTES);
          end else begin
            fetch_pc_s = fetch_pc_r;
          end
          if (push_s) begin
            rsp_pc_s = rsp_pc_r + PC_W'(INSTR_BYTES);
          end else begin
            rsp_pc_s = rsp_pc_r;
          end
        end
        DRAIN: begin
          if (rsp_s) begin
            drop_s = drop_r - CW'(1);
            if (drop_r == CW'(1)) begin
              state_s = FETCH;
            end else begin
              state_s = DRAIN;
            end
          end else begin
            drop_s = drop_r;
          end
        end
        default: state_s = FETCH;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= FETCH;
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= '0;
      drop_r        <= '0;
      misaligned_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      fetch_pc_r    <= fetch_pc_s;
      rsp_pc_r      <= rsp_pc_s;
      outstanding_r <= outstanding_s;
      drop_r        <= drop_s;
      misaligned_r  <= Redirect && (RedirectPC[1:0] != 2'b00);
    end
  end

  fetch_buffer #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_pc   (rsp_pc_r),
    .push_data (ImemRspData),
    .pop       (pop_s),
    .flush     (Redirect),
    .head_pc   (InstrPC),
    .head_data (Instruction),
    .count     (buf_count_s)
  );

  assign ImemReqValid = req_valid_s;
  assign ImemReqAddr  = fetch_pc_r;
  assign InstrValid   = (buf_count_s != CW'(0));
  assign Misaligned   = misaligned_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a program-order model of requests and delivered instructions.
module tb_fetch_unit;

  localparam int          BITS     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic            clk = 1'b0;
  logic            rst;
  logic            ImemReqValid;
  logic            ImemReqReady;
  logic [63:0]     ImemReqAddr;
  logic            ImemRspValid;
  logic [BITS-1:0] ImemRspData;
  logic            Redirect;
  logic [63:0]     RedirectPC;
  logic            InstrValid;
  logic            InstrReady;
  logic [BITS-1:0] Instruction;
  logic [63:0]     InstrPC;
  logic            Misaligned;

  always #5 clk = ~clk;

  fetch_unit #(.BITS(BITS), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemReqAddr(ImemReqAddr),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instruction(Instruction), .InstrPC(InstrPC), .Misaligned(Misaligned)
  );

  typedef struct {
    logic [63:0] a;
    int          t;
  } mreq_t;

  mreq_t       memq[$];
  logic [63:0] exp_req, exp_instr;
  int          drain_left;
  logic        mis_exp;
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        obs_reqv, obs_acc, obs_ivalid, obs_mis;
  logic [63:0] obs_addr, obs_ipc;

  function automatic logic [BITS-1:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3 ^ {a[47:32], a[63:48]};
  endfunction

  function automatic logic [63:0] aligned(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    exp_req    = RESET_PC;
    exp_instr  = RESET_PC;
    drain_left = 0;
    mis_exp    = 1'b0;
  endtask

  // One clock cycle: drive inputs after the edge, sample and check at negedge.
  task automatic cycle(input logic rdr, input logic [63:0] tgt, input logic rq_rdy,
                       input logic in_rdy, input int rsp_pct);
    logic rsp;
    Redirect     = rdr;
    RedirectPC   = tgt;
    ImemReqReady = rq_rdy;
    InstrReady   = in_rdy;
    rsp = 1'b0;
    if (memq.size() > 0) begin
      if (memq[0].t < cyc && int'($urandom_range(99, 0)) < rsp_pct) rsp = 1'b1;
    end
    ImemRspValid = rsp;
    ImemRspData  = rsp ? mem_word(memq[0].a) : BITS'($urandom);
    @(negedge clk);
    obs_reqv   = ImemReqValid;
    obs_addr   = ImemReqAddr;
    obs_acc    = ImemReqValid && ImemReqReady;
    obs_ivalid = InstrValid;
    obs_ipc    = InstrPC;
    obs_mis    = Misaligned;
    chk("misaligned", 64'(Misaligned), 64'(mis_exp));
    if (rdr) chk("req_during_redirect", 64'(ImemReqValid), 64'd0);
    if (drain_left > 0) chk("req_during_drain", 64'(ImemReqValid), 64'd0);
    if (ImemReqValid) chk("req_addr", ImemReqAddr, exp_req);
    if (InstrValid) begin
      chk("instr_pc", InstrPC, exp_instr);
      chk("instr_data", 64'(Instruction), 64'(mem_word(exp_instr)));
    end
    if (rsp) begin
      void'(memq.pop_front());
      if (drain_left > 0) drain_left--;
    end
    if (obs_acc) begin
      memq.push_back('{a: exp_req, t: cyc});
      exp_req = exp_req + 64'd4;
    end
    if (InstrValid && in_rdy && !rdr) exp_instr = exp_instr + 64'd4;
    if (rdr) begin
      exp_req    = aligned(tgt);
      exp_instr  = aligned(tgt);
      drain_left = memq.size();
    end
    mis_exp = rdr && (tgt[1:0] != 2'b00);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int          n_acc;
    int          n_got;
    logic        found;
    logic [63:0] e;
    logic [63:0] first_a, second_a;
    logic [63:0] tgt;
    logic        rdr;

    rst          = 1'b1;
    ImemReqReady = 1'b0;
    ImemRspValid = 1'b1;
    ImemRspData  = 32'hDEAD_BEEF;
    Redirect     = 1'b0;
    RedirectPC   = 64'h0;
    InstrReady   = 1'b0;
    cyc          = 0;
    model_reset();

    // Reset values; responses offered during reset must be ignored
    @(negedge clk);
    chk("rst_req_valid", 64'(ImemReqValid), 64'd0);
    chk("rst_instr_valid", 64'(InstrValid), 64'd0);
    chk("rst_misaligned", 64'(Misaligned), 64'd0);
    chk("rst_instruction", 64'(Instruction), 64'd0);
    chk("rst_instr_pc", InstrPC, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    ImemRspValid = 1'b0;
    model_reset();
    cyc = 1;

    // Streaming with a 1-cycle memory: first instruction visible in cycle 3
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("c1_req_valid", 64'(obs_reqv), 64'd1);
    chk("c1_req_addr", obs_addr, RESET_PC);
    chk("c1_instr_valid", 64'(obs_ivalid), 64'd0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("c2_instr_valid", 64'(obs_ivalid), 64'd0);
    chk("c2_req_addr", obs_addr, RESET_PC + 64'd4);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("c3_instr_valid", 64'(obs_ivalid), 64'd1);
    chk("c3_instr_pc", obs_ipc, RESET_PC);
    repeat (8) cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);

    // Controller stalled: exactly DEPTH requests, then back-pressure, no loss
    repeat (6) cycle(1'b0, 64'h0, 1'b0, 1'b1, 100);
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b0, 100);
      if (obs_acc) n_acc++;
    end
    chk("stall_req_count", 64'(n_acc), 64'(DEPTH));
    chk("stall_req_valid_low", 64'(obs_reqv), 64'd0);
    e = exp_instr;
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("resume_instr_valid", 64'(obs_ivalid), 64'd1);
    chk("resume_instr_pc", obs_ipc, e);
    repeat (8) cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);

    // Redirect to 0x100 with two responses outstanding
    repeat (6) cycle(1'b0, 64'h0, 1'b0, 1'b1, 100);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
    chk("rd_setup_acc0", 64'(obs_acc), 64'd1);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 0);
    chk("rd_setup_acc1", 64'(obs_acc), 64'd1);
    cycle(1'b1, 64'h100, 1'b1, 1'b1, 0);
    chk("rd_req_blocked", 64'(obs_reqv), 64'd0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("drain0_req_valid", 64'(obs_reqv), 64'd0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("drain1_req_valid", 64'(obs_reqv), 64'd0);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("post_drain_req_valid", 64'(obs_reqv), 64'd1);
    chk("post_drain_req_addr", obs_addr, 64'h100);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
      if (obs_ivalid) begin
        chk("rd_first_instr_pc", obs_ipc, 64'h100);
        found = 1'b1;
        break;
      end
    end
    chk("rd_first_instr_seen", 64'(found), 64'd1);

    // Misaligned redirect: one-cycle pulse, fetch resumes at aligned address
    found   = 1'b0;
    first_a = 64'h0;
    cycle(1'b1, 64'h102, 1'b1, 1'b1, 100);
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("mis_pulse", 64'(obs_mis), 64'd1);
    if (obs_acc) begin found = 1'b1; first_a = obs_addr; end
    cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
    chk("mis_clear", 64'(obs_mis), 64'd0);
    if (obs_acc && !found) begin found = 1'b1; first_a = obs_addr; end
    for (int i = 0; i < 10; i++) begin
      if (!found) begin
        cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
        if (obs_acc) begin found = 1'b1; first_a = obs_addr; end
      end
    end
    chk("mis_resume_seen", 64'(found), 64'd1);
    chk("mis_resume_addr", first_a, 64'h100);

    // Fetch address wraps silently past the top of the address space
    n_got    = 0;
    first_a  = 64'h1;
    second_a = 64'h1;
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 100);
    for (int i = 0; i < 20; i++) begin
      if (n_got < 2) begin
        cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
        if (obs_acc) begin
          if (n_got == 0) first_a = obs_addr;
          else second_a = obs_addr;
          n_got++;
        end
      end
    end
    chk("wrap_req_count", 64'(n_got), 64'd2);
    chk("wrap_first_addr", first_a, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_second_addr", second_a, 64'h0);

    // Asynchronous reset with a full buffer
    repeat (20) cycle(1'b0, 64'h0, 1'b1, 1'b0, 100);
    chk("full_instr_valid", 64'(obs_ivalid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_instr_valid", 64'(InstrValid), 64'd0);
    chk("async_req_valid", 64'(ImemReqValid), 64'd0);
    chk("async_instr_pc", InstrPC, 64'd0);
    ImemRspValid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    ImemRspValid = 1'b0;
    model_reset();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b1, 100);
      if (obs_ivalid) begin
        chk("post_rst_instr_pc", obs_ipc, RESET_PC);
        found = 1'b1;
        break;
      end
    end
    chk("post_rst_instr_seen", 64'(found), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rdr = (int'($urandom_range(99, 0)) < 4);
      case ($urandom_range(2, 0))
        0:       tgt = 64'($urandom_range(255, 0));
        1:       tgt = {$urandom, $urandom};
        default: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
      endcase
      cycle(rdr, tgt, int'($urandom_range(99, 0)) < 70, int'($urandom_range(99, 0)) < 70, 60);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BITS, default 32, instruction width delivered to the controller.
REQ-002 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 Parameter DEPTH, default 2, instruction buffer entries; legal values 2 and 4 only.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ImemReqValid  output  1  fetch request to instruction memory.
REQ-007 ImemReqReady  input  1  memory accepts request this cycle.
REQ-008 ImemReqAddr  output  64  word-aligned fetch address.
REQ-009 ImemRspValid  input  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-010 ImemRspData  input  BITS  fetched instruction word.
REQ-011 Redirect  input  1  branch/jump taken; overrides all other events.
REQ-012 RedirectPC  input  64  target address for Redirect.
REQ-013 InstrValid  output  1  Instruction/InstrPC valid for the controller stage.
REQ-014 InstrReady  input  1  controller stage consumes the instruction this cycle.
REQ-015 Instruction  output  BITS  instruction word, same bit ordering as the controller's Instruction input.
REQ-016 InstrPC  output  64  address of Instruction.
REQ-017 Misaligned  output  1  one-cycle pulse: RedirectPC[1:0] was nonzero.

Function
REQ-018 FetchPC register holds the next request address; a request is accepted when ImemReqValid && ImemReqReady, then FetchPC += 4 (mod 2^64, wrap silently).
REQ-019 ImemReqValid is 1 only in state FETCH and only when Outstanding + BufCount < DEPTH (no response can ever be dropped for lack of space).
REQ-020 Outstanding counter: +1 on accepted request, -1 on ImemRspValid, both in one cycle leaves it unchanged.
REQ-021 Each in-state-FETCH response is pushed to the buffer tail with its PC (PC FIFO tracks issued addresses).
REQ-022 Buffer head drives Instruction/InstrPC; InstrValid = BufCount != 0; pop on InstrValid && InstrReady; simultaneous push and pop at full or empty is legal and keeps count consistent.
REQ-023 Zero-latency bypass is not provided: response to InstrValid latency is exactly 1 cycle.
REQ-024 States: FETCH, DRAIN.
REQ-025 Redirect in any state: buffer flushed (BufCount=0), FetchPC <= {RedirectPC[63:2],2'b00}, no pop counted, no request issued that cycle.
REQ-026 Redirect with Outstanding (after this cycle's updates) > 0 -> DRAIN, DropCount loaded with that value; otherwise stay/enter FETCH.
REQ-027 DRAIN: every ImemRspValid decrements DropCount and Outstanding, data discarded; no requests; DropCount reaching 0 -> FETCH next cycle.
REQ-028 Redirect during DRAIN reloads FetchPC and DropCount (current Outstanding); state stays DRAIN if nonzero.
REQ-029 Misaligned = 1 for exactly the cycle after a Redirect with RedirectPC[1:0] != 0, else 0.
REQ-030 ImemRspValid with Outstanding == 0 is a protocol error; response ignored, counters unchanged.

Reset
REQ-031 rst asserted: state FETCH, FetchPC = RESET_PC, Outstanding = 0, DropCount = 0, BufCount = 0, InstrValid = 0, ImemReqValid = 0, Misaligned = 0, Instruction = 0, InstrPC = 0.
REQ-032 First request is issued in the first cycle after rst deasserts; responses arriving while rst high are discarded.
REQ-033 rst mid-operation discards all buffered and outstanding fetches; memory is responsible for cancelling in-flight responses.

Structure
REQ-034 Shared package: fetch state enum (FETCH, DRAIN), INSTR_BYTES = 4, PC width 64, NOP encoding 32'h00000013.
REQ-035 One sub-module: fetch_buffer, a DEPTH-entry synchronous FIFO of {PC, instruction} with push, pop, flush, count.

Verification
REQ-036 Reset, ImemReqReady=1, 1-cycle memory: requests at 0x0,0x4,0x8...; InstrValid on cycle 3; InstrPC sequence 0x0,0x4,0x8.
REQ-037 InstrReady=0 for 10 cycles: exactly DEPTH requests issued, then ImemReqValid=0; no data loss when InstrReady returns.
REQ-038 Redirect to 0x100 with 2 responses outstanding: DRAIN for 2 responses, both discarded, next InstrPC = 0x100.
REQ-039 Redirect to 0x102: Misaligned pulses 1 cycle, fetch resumes at 0x100.
REQ-040 rst asserted with full buffer: InstrValid falls asynchronously, first post-reset InstrPC = RESET_PC.
REQ-041 FetchPC = 64'hFFFF_FFFF_FFFF_FFFC: next request address 0x0.
